// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial subtractor D = A - B - b_i with start/done handshake
// Optional two's-complement overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int width = 16,
    parameter int digit = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             b_i,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] D,
    output logic             b_o,
    output logic             ovf
);
    localparam int N  = width / digit;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [width-1:0]  a_q, a_d, b_q, b_d;
    logic [width-1:0]  acc_q, acc_d, acc_next;
    logic [width-1:0]  res_q, res_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              borrow_q, borrow_d;
    logic              bo_q, bo_d;
    logic [digit:0]    diff;
`ifdef SERIAL_SUB_OVF_EN
    logic              a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic              ovf_q, ovf_d;
`endif

    // One digit per cycle; the extra top bit of diff is the borrow out of this digit.
    always_comb begin
        diff     = {1'b0, a_q[digit-1:0]} - {1'b0, b_q[digit-1:0]} - {{digit{1'b0}}, borrow_q};
        acc_next = (acc_q >> digit) | (width'(diff[digit-1:0]) << (width - digit));
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bo_d     = bo_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = b_i;
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d  = A[width-1];
                    b_msb_d  = B[width-1];
`endif
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_next;
                a_d      = a_q >> digit;
                b_d      = b_q >> digit;
                borrow_d = diff[digit];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    res_d   = acc_next;
                    bo_d    = diff[digit];
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (acc_next[width-1] != a_msb_q);
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bo_q     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bo_q     <= bo_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign D    = res_q;
    assign b_o  = bo_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`else
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (digit=4 and digit=1 instances)
module tb_serial_subtractor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start4, bi4, start1, bi1;
    logic [15:0] a4, b4, a1, b1;
    logic        busy4, done4, bo4, ovf4;
    logic        busy1, done1, bo1, ovf1;
    logic [15:0] d4, d1;

    serial_subtractor #(.width(16), .digit(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .b_i(bi4),
        .busy(busy4), .done(done4), .D(d4), .b_o(bo4), .ovf(ovf4));

    serial_subtractor #(.width(16), .digit(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .b_i(bi1),
        .busy(busy1), .done(done1), .D(d1), .b_o(bo1), .ovf(ovf1));

    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        ov;
        int          t0;
    } exp_t;

    exp_t        q4[$];
    exp_t        q1[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_d4 = 16'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] aa, input logic [15:0] bb,
                                   input logic bi, input int t0);
        exp_t        e;
        logic [16:0] r;
        r    = {1'b0, aa} - {1'b0, bb} - {16'h0, bi};
        e.d  = r[15:0];
        e.bo = r[16];
`ifdef SERIAL_SUB_OVF_EN
        e.ov = (aa[15] != bb[15]) && (r[15] != aa[15]);
`else
        e.ov = 1'b0;
`endif
        e.t0 = t0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_done_excl4", 32'(busy4 & done4), 32'd0);
            chk("busy_done_excl1", 32'(busy1 & done1), 32'd0);
            if (done4) begin
                if (q4.size() == 0) chk("unexpected_done4", 32'(done4), 32'd0);
                else begin
                    exp_t e;
                    e = q4.pop_front();
                    chk("d4", 32'(d4), 32'(e.d));
                    chk("bo4", 32'(bo4), 32'(e.bo));
                    chk("ovf4", 32'(ovf4), 32'(e.ov));
                    chk("latency4", 32'(cyc - e.t0), 32'd4);
                    last_d4 = e.d;
                end
            end
            if (done1) begin
                if (q1.size() == 0) chk("unexpected_done1", 32'(done1), 32'd0);
                else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("d1", 32'(d1), 32'(e.d));
                    chk("bo1", 32'(bo1), 32'(e.bo));
                    chk("latency1", 32'(cyc - e.t0), 32'd16);
                end
            end
        end
    end

    task automatic wait_idle4();
        for (int i = 0; i < 200 && (busy4 || done4); i++) @(negedge clk);
        chk("idle_timeout4", 32'({busy4, done4}), 32'd0);
    endtask

    task automatic op4(input logic [15:0] aa, input logic [15:0] bb, input logic bi, input bit push);
        wait_idle4();
        a4 = aa; b4 = bb; bi4 = bi; start4 = 1'b1;
        if (push) q4.push_back(model(aa, bb, bi, cyc + 1));
        @(negedge clk);
        start4 = 1'b0;
        a4 = 16'($urandom); b4 = 16'($urandom); bi4 = 1'($urandom);
    endtask

    task automatic op1(input logic [15:0] aa, input logic [15:0] bb, input logic bi);
        for (int i = 0; i < 200 && (busy1 || done1); i++) @(negedge clk);
        chk("idle_timeout1", 32'({busy1, done1}), 32'd0);
        a1 = aa; b1 = bb; bi1 = bi; start1 = 1'b1;
        q1.push_back(model(aa, bb, bi, cyc + 1));
        @(negedge clk);
        start1 = 1'b0;
        a1 = 16'($urandom); b1 = 16'($urandom);
    endtask

    initial begin
        rst_n = 1'b0; start4 = 1'b0; start1 = 1'b0;
        a4 = '0; b4 = '0; bi4 = 1'b0; a1 = '0; b1 = '0; bi1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs4", 32'({busy4, done4, bo4, ovf4, d4}), 32'd0);
        chk("reset_outs1", 32'({busy1, done1, bo1, ovf1, d1}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op4(16'h0005, 16'h0003, 1'b0, 1'b1);
        chk("busy_after_start", 32'(busy4), 32'd1);
        op4(16'h0000, 16'h0001, 1'b0, 1'b1);
        op4(16'h1234, 16'h1234, 1'b1, 1'b1);
        op4(16'h8000, 16'h0001, 1'b0, 1'b1);
        op4(16'h0003, 16'h0001, 1'b0, 1'b1);

        // Requests during RUN and DONE must be dropped.
        op4(16'h0010, 16'h0001, 1'b0, 1'b1);
        a4 = 16'hFFFF; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 50 && !done4; i++) @(negedge clk);
        chk("done_seen_ignore", 32'(done4), 32'd1);
        a4 = 16'hFFFF; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        chk("idle_after_ignored", 32'({busy4, done4}), 32'd0);
        op4(16'h0042, 16'h0002, 1'b0, 1'b1);

        // Abort in RUN cycle 2; no done may follow for this operation.
        op4(16'h1111, 16'h0101, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_outs", 32'({busy4, done4, bo4, ovf4, d4}), 32'd0);
        repeat (6) @(negedge clk);
        op4(16'h0009, 16'h0004, 1'b0, 1'b1);

        for (int i = 0; i < 25; i++)
            op4(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);

        op1(16'hABCD, 16'h1234, 1'b0);
        for (int i = 0; i < 4; i++)
            op1(16'($urandom), 16'($urandom), 1'($urandom));

        for (int i = 0; i < 200 && (q4.size() + q1.size()) != 0; i++) @(negedge clk);
        chk("drain", 32'(q4.size() + q1.size()), 32'd0);
        repeat (5) @(negedge clk);
        chk("hold_d4", 32'(d4), 32'(last_d4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
